// File: rtl/cpu_pkg.sv
// Shared constants for the 5-stage MIPS core: datapath widths, control-bundle
// bit positions and the bubble control word.
package cpu_pkg;

    localparam int DW = 32;  // datapath width
    localparam int RW = 5;   // register-address width
    localparam int SW = 5;   // shift-amount width
    localparam int CW = 12;  // decoded control bundle width

    // Control-bundle bit layout
    localparam int CTRL_ALUSRC  = 0;
    localparam int CTRL_MEMRD   = 1;
    localparam int CTRL_MEMWR   = 2;
    localparam int CTRL_REGWR   = 3;
    localparam int CTRL_MEM2REG = 4;
    localparam int CTRL_REGDST  = 5;
    localparam int CTRL_ALUOP_LO = 6;
    localparam int CTRL_ALUOP_HI = 9;
    localparam int CTRL_BRANCH  = 10;
    localparam int CTRL_JUMP    = 11;

    localparam logic [CW-1:0] NOP_CTRL = '0;

    // True when a write-back targets the given register specifier; $0 is never a target.
    function automatic logic wb_hits(input logic we, input logic [RW-1:0] waddr,
                                     input logic [RW-1:0] tag);
        return we && (waddr != '0) && (waddr == tag);
    endfunction

endpackage

// File: rtl/id_ex_reg_pipe_field.sv
// pipe_field: one pipeline-register field with async active-low reset,
// synchronous clear (takes priority) and load enable.
module pipe_field #(
    parameter int           W       = 32,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = CLR_VAL;
        end else if (en_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= CLR_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall, flush and write-back capture of held operands.
// Optional build macro ID_EX_PERF_CNT_EN adds bubble/stall event counters.
module id_ex_reg
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall_i,
    input  logic          flush_i,
    input  logic          id_valid_i,
    input  logic [DW-1:0] id_pc_i,
    input  logic [DW-1:0] id_rs_data_i,
    input  logic [DW-1:0] id_rt_data_i,
    input  logic [DW-1:0] id_imm_i,
    input  logic [RW-1:0] id_rs_i,
    input  logic [RW-1:0] id_rt_i,
    input  logic [RW-1:0] id_rd_i,
    input  logic [SW-1:0] id_shamt_i,
    input  logic [CW-1:0] id_ctrl_i,
    input  logic          wb_we_i,
    input  logic [RW-1:0] wb_waddr_i,
    input  logic [DW-1:0] wb_wdata_i,
    output logic          ex_valid_o,
    output logic [DW-1:0] ex_pc_o,
    output logic [DW-1:0] ex_rs_data_o,
    output logic [DW-1:0] ex_rt_data_o,
    output logic [DW-1:0] ex_imm_o,
    output logic [RW-1:0] ex_rs_o,
    output logic [RW-1:0] ex_rt_o,
    output logic [RW-1:0] ex_rd_o,
    output logic [SW-1:0] ex_shamt_o,
    output logic [CW-1:0] ex_ctrl_o
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]   perf_bubble_o,
    output logic [31:0]   perf_stall_o
`endif
);

    // Flush clears every field (clear wins over enable inside pipe_field);
    // stall deasserts the enable so fields hold.
    logic          load_en;
    logic          rs_cap;
    logic          rt_cap;
    logic          rs_data_en;
    logic          rt_data_en;
    logic [DW-1:0] rs_data_in;
    logic [DW-1:0] rt_data_in;

    assign load_en = ~stall_i;

    // While held, a retiring write to a held source register refreshes its operand.
    // On a normal load the register file is write-first, so no capture is needed.
    always_comb begin
        rs_cap     = stall_i && ex_valid_o && wb_hits(wb_we_i, wb_waddr_i, ex_rs_o);
        rt_cap     = stall_i && ex_valid_o && wb_hits(wb_we_i, wb_waddr_i, ex_rt_o);
        rs_data_en = load_en | rs_cap;
        rt_data_en = load_en | rt_cap;
        rs_data_in = id_rs_data_i;
        rt_data_in = id_rt_data_i;
        if (stall_i) begin
            rs_data_in = wb_wdata_i;
            rt_data_in = wb_wdata_i;
        end
    end

    pipe_field #(.W(1)) u_valid (
        .clk(clk), .rst_n(rst_n), .clr_i(flush_i), .en_i(load_en),
        .d_i(id_valid_i), .q_o(ex_valid_o)
    );

    pipe_field #(.W(DW)) u_pc (
        .clk(clk), .rst_n(rst_n), .clr_i(flush_i), .en_i(load_en),
        .d_i(id_pc_i), .q_o(ex_pc_o)
    );

    pipe_field #(.W(DW)) u_imm (
        .clk(clk), .rst_n(rst_n), .clr_i(flush_i), .en_i(load_en),
        .d_i(id_imm_i), .q_o(ex_imm_o)
    );

    pipe_field #(.W(DW)) u_rs_data (
        .clk(clk), .rst_n(rst_n), .clr_i(flush_i), .en_i(rs_data_en),
        .d_i(rs_data_in), .q_o(ex_rs_data_o)
    );

    pipe_field #(.W(DW)) u_rt_data (
        .clk(clk), .rst_n(rst_n), .clr_i(flush_i), .en_i(rt_data_en),
        .d_i(rt_data_in), .q_o(ex_rt_data_o)
    );

    pipe_field #(.W(RW)) u_rs (
        .clk(clk), .rst_n(rst_n), .clr_i(flush_i), .en_i(load_en),
        .d_i(id_rs_i), .q_o(ex_rs_o)
    );

    pipe_field #(.W(RW)) u_rt (
        .clk(clk), .rst_n(rst_n), .clr_i(flush_i), .en_i(load_en),
        .d_i(id_rt_i), .q_o(ex_rt_o)
    );

    pipe_field #(.W(RW)) u_rd (
        .clk(clk), .rst_n(rst_n), .clr_i(flush_i), .en_i(load_en),
        .d_i(id_rd_i), .q_o(ex_rd_o)
    );

    pipe_field #(.W(SW)) u_shamt (
        .clk(clk), .rst_n(rst_n), .clr_i(flush_i), .en_i(load_en),
        .d_i(id_shamt_i), .q_o(ex_shamt_o)
    );

    pipe_field #(.W(CW), .CLR_VAL(NOP_CTRL)) u_ctrl (
        .clk(clk), .rst_n(rst_n), .clr_i(flush_i), .en_i(load_en),
        .d_i(id_ctrl_i), .q_o(ex_ctrl_o)
    );

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] perf_bubble_d;
    logic [31:0] perf_bubble_q;
    logic [31:0] perf_stall_d;
    logic [31:0] perf_stall_q;

    always_comb begin
        perf_bubble_d = perf_bubble_q;
        perf_stall_d  = perf_stall_q;
        if (flush_i) begin
            perf_bubble_d = perf_bubble_q + 32'd1;
        end else if (stall_i) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bubble_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_bubble_q <= perf_bubble_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_bubble_o = perf_bubble_q;
    assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: reference model feeds an expected queue,
// each scenario task pops and compares after the clock edge.
module tb_id_ex_reg;
    import cpu_pkg::*;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [SW-1:0] shamt;
        logic [CW-1:0] ctrl;
    } bundle_t;

    localparam int BW = $bits(bundle_t);

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          stall_i, flush_i, wb_we_i;
    logic [RW-1:0] wb_waddr_i;
    logic [DW-1:0] wb_wdata_i;
    bundle_t       id_b;
    bundle_t       mdl;
    bundle_t       dut_out;

    logic          ex_valid_o;
    logic [DW-1:0] ex_pc_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o;
    logic [RW-1:0] ex_rs_o, ex_rt_o, ex_rd_o;
    logic [SW-1:0] ex_shamt_o;
    logic [CW-1:0] ex_ctrl_o;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]   perf_bubble_o, perf_stall_o;
`endif

    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] exp_v;
    int checks = 0;
    int passes = 0;

    assign dut_out = {ex_valid_o, ex_pc_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o,
                      ex_rs_o, ex_rt_o, ex_rd_o, ex_shamt_o, ex_ctrl_o};

    id_ex_reg dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .id_valid_i(id_b.valid), .id_pc_i(id_b.pc), .id_rs_data_i(id_b.rs_data),
        .id_rt_data_i(id_b.rt_data), .id_imm_i(id_b.imm), .id_rs_i(id_b.rs),
        .id_rt_i(id_b.rt), .id_rd_i(id_b.rd), .id_shamt_i(id_b.shamt),
        .id_ctrl_i(id_b.ctrl), .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i),
        .wb_wdata_i(wb_wdata_i), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
        .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o), .ex_imm_o(ex_imm_o),
        .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o),
        .ex_shamt_o(ex_shamt_o), .ex_ctrl_o(ex_ctrl_o)
`ifdef ID_EX_PERF_CNT_EN
        , .perf_bubble_o(perf_bubble_o), .perf_stall_o(perf_stall_o)
`endif
    );

    // driver tasks
    function automatic bundle_t rand_id();
        bundle_t b;
        b.valid   = 1'b1;
        b.pc      = $urandom;
        b.rs_data = $urandom;
        b.rt_data = $urandom;
        b.imm     = $urandom;
        b.rs      = RW'($urandom_range(1, 31));
        b.rt      = RW'($urandom_range(1, 31));
        b.rd      = RW'($urandom_range(0, 31));
        b.shamt   = SW'($urandom_range(0, 31));
        b.ctrl    = CW'($urandom);
        return b;
    endfunction

    task automatic set_ctl(input logic st, input logic fl, input logic we,
                           input logic [RW-1:0] wa, input logic [DW-1:0] wd);
        stall_i    = st;
        flush_i    = fl;
        wb_we_i    = we;
        wb_waddr_i = wa;
        wb_wdata_i = wd;
    endtask

    // Reference model of one edge, then clock; leaves time at edge + 1.
    task automatic step();
        bundle_t nxt;
        nxt = mdl;
        if (flush_i) begin
            nxt = '0;
        end else if (!stall_i) begin
            nxt = id_b;
        end else if (mdl.valid && wb_we_i && wb_waddr_i != '0) begin
            if (wb_waddr_i == mdl.rs) nxt.rs_data = wb_wdata_i;
            if (wb_waddr_i == mdl.rt) nxt.rt_data = wb_wdata_i;
        end
        mdl = nxt;
        exp_q.push_back(nxt);
        @(posedge clk);
        #1;
    endtask

    // scenario tasks
    task automatic test_reset();
        set_ctl(1'b0, 1'b0, 1'b0, '0, '0);
        id_b = '0;
        mdl  = '0;
        #12;
        checks++;
        if (dut_out !== '0) $display("FAIL reset_hold got %h exp 0", dut_out);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load();
        id_b       = rand_id();
        id_b.imm   = 32'hFFFF8000;
        id_b.pc    = 32'h00400004;
        id_b.rs    = 5'd8;
        id_b.ctrl  = 12'h0A5;
        set_ctl(1'b0, 1'b0, 1'b0, '0, '0);
        step();
        exp_v = exp_q.pop_front();
        checks++;
        if (dut_out !== exp_v) $display("FAIL load_vec got %h exp %h", dut_out, exp_v);
        else passes++;
        checks++;
        if ({ex_imm_o, ex_pc_o, ex_rs_o, ex_ctrl_o, ex_valid_o} !==
            {32'hFFFF8000, 32'h00400004, 5'd8, 12'h0A5, 1'b1})
            $display("FAIL load_fields got imm=%h pc=%h rs=%0d ctrl=%h v=%b",
                     ex_imm_o, ex_pc_o, ex_rs_o, ex_ctrl_o, ex_valid_o);
        else passes++;
    endtask

    task automatic test_stall_capture();
        bundle_t a;
        a         = rand_id();
        a.rs      = 5'd8;
        a.rs_data = 32'h11;
        a.rt      = 5'd9;
        a.rt_data = 32'h22;
        id_b = a;
        set_ctl(1'b0, 1'b0, 1'b0, '0, '0);
        step();
        // hold with a matching write-back, new ID contents must not leak
        id_b = rand_id();
        set_ctl(1'b1, 1'b0, 1'b1, 5'd8, 32'hDEADBEEF);
        step();
        a.rs_data = 32'hDEADBEEF;
        checks++;
        if (dut_out !== a) $display("FAIL capture_rs got %h exp %h", dut_out, a);
        else passes++;
        set_ctl(1'b1, 1'b0, 1'b1, 5'd0, 32'h12345678);
        step();
        checks++;
        if (dut_out !== a) $display("FAIL capture_r0 got %h exp %h", dut_out, a);
        else passes++;
        // both operands name the same register
        a = rand_id();
        a.rs = 5'd12;
        a.rt = 5'd12;
        id_b = a;
        set_ctl(1'b0, 1'b0, 1'b0, '0, '0);
        step();
        set_ctl(1'b1, 1'b0, 1'b1, 5'd12, 32'hCAFEF00D);
        step();
        checks++;
        if ({ex_rs_data_o, ex_rt_data_o} !== {32'hCAFEF00D, 32'hCAFEF00D})
            $display("FAIL capture_both got rs=%h rt=%h exp CAFEF00D", ex_rs_data_o, ex_rt_data_o);
        else passes++;
        // invalid slot is never refreshed
        a = rand_id();
        a.valid = 1'b0;
        a.rs = 5'd8;
        a.rs_data = 32'h5;
        id_b = a;
        set_ctl(1'b0, 1'b0, 1'b0, '0, '0);
        step();
        set_ctl(1'b1, 1'b0, 1'b1, 5'd8, 32'h99);
        step();
        checks++;
        if (ex_rs_data_o !== 32'h5) $display("FAIL capture_invalid got %h exp 00000005", ex_rs_data_o);
        else passes++;
        // load with concurrent write-back takes the ID value
        a = rand_id();
        a.rs = 5'd8;
        a.rs_data = 32'h77;
        id_b = a;
        set_ctl(1'b0, 1'b0, 1'b1, 5'd8, 32'h99);
        step();
        checks++;
        if (ex_rs_data_o !== 32'h77) $display("FAIL load_no_capture got %h exp 00000077", ex_rs_data_o);
        else passes++;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
        end
        checks++;
        if (dut_out !== mdl) $display("FAIL capture_model got %h exp %h", dut_out, mdl);
        else passes++;
    endtask

    task automatic test_flush_stall();
        id_b = rand_id();
        set_ctl(1'b0, 1'b0, 1'b0, '0, '0);
        step();
        exp_v = exp_q.pop_front();
        id_b = rand_id();
        set_ctl(1'b1, 1'b1, 1'b1, id_b.rs, $urandom);
        step();
        exp_v = exp_q.pop_front();
        checks++;
        if (dut_out !== exp_v) $display("FAIL flush_vec got %h exp %h", dut_out, exp_v);
        else passes++;
        checks++;
        if ({ex_valid_o, ex_ctrl_o, ex_rs_o, ex_rt_o, ex_rd_o} !== '0)
            $display("FAIL flush_fields got v=%b ctrl=%h rs=%0d rt=%0d rd=%0d exp 0",
                     ex_valid_o, ex_ctrl_o, ex_rs_o, ex_rt_o, ex_rd_o);
        else passes++;
    endtask

    task automatic test_back_to_back();
        bundle_t a, b;
        a = rand_id();
        b = rand_id();
        id_b = a;
        set_ctl(1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                id_b = b;
                set_ctl(1'b1, 1'b0, 1'b0, '0, '0);
            end else if (i == 3) begin
                set_ctl(1'b0, 1'b0, 1'b0, '0, '0);
            end
            step();
            exp_v = exp_q.pop_front();
            checks++;
            if (dut_out !== ((i < 3) ? a : b))
                $display("FAIL b2b_cycle%0d got %h exp %h", i, dut_out, (i < 3) ? a : b);
            else passes++;
        end
    endtask

    task automatic test_random();
        int sel;
        for (int i = 0; i < 60; i++) begin
            id_b = rand_id();
            id_b.valid = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 3);
            set_ctl($urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 3) != 0,
                    (sel == 0) ? mdl.rs : (sel == 1) ? mdl.rt : (sel == 2) ? 5'd0 : RW'($urandom),
                    $urandom);
            step();
            exp_v = exp_q.pop_front();
            checks++;
            if (dut_out !== exp_v) $display("FAIL random_%0d got %h exp %h", i, dut_out, exp_v);
            else passes++;
        end
    endtask

    task automatic test_async_reset();
        id_b = rand_id();
        set_ctl(1'b0, 1'b0, 1'b0, '0, '0);
        step();
        exp_v = exp_q.pop_front();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        mdl = '0;
        #1;
        checks++;
        if (dut_out !== '0 || ex_ctrl_o !== NOP_CTRL)
            $display("FAIL async_reset got %h exp 0", dut_out);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef ID_EX_PERF_CNT_EN
    task automatic test_perf();
        @(negedge clk);
        rst_n = 1'b0;
        mdl = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            id_b = rand_id();
            case (i)
                0, 4:    set_ctl(1'b0, 1'b1, 1'b0, '0, '0);
                7:       set_ctl(1'b1, 1'b1, 1'b0, '0, '0);
                1, 2, 3, 5, 6: set_ctl(1'b1, 1'b0, 1'b0, '0, '0);
                default: set_ctl(1'b0, 1'b0, 1'b0, '0, '0);
            endcase
            step();
            exp_v = exp_q.pop_front();
        end
        checks++;
        if (perf_bubble_o !== 32'd3 || perf_stall_o !== 32'd5)
            $display("FAIL perf_counts got bubble=%0d stall=%0d exp 3 5", perf_bubble_o, perf_stall_o);
        else passes++;
        force dut.perf_bubble_q = 32'hFFFFFFFF;
        #1;
        release dut.perf_bubble_q;
        set_ctl(1'b0, 1'b1, 1'b0, '0, '0);
        step();
        exp_v = exp_q.pop_front();
        checks++;
        if (perf_bubble_o !== 32'd0 || perf_stall_o !== 32'd5)
            $display("FAIL perf_wrap got bubble=%h stall=%0d exp 0 5", perf_bubble_o, perf_stall_o);
        else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_stall_capture();
        test_flush_stall();
        test_back_to_back();
        test_random();
        test_async_reset();
`ifdef ID_EX_PERF_CNT_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
